// File: rtl/fetch_stage.sv
// Instruction fetch stage with F/D pipeline register and a one-entry skid buffer.
// Optional FETCH_PERF_EN adds saturating fetch/stall event counters.
module fetch_stage #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    output logic [31:0]       fd_insn,
    output logic [ADDR_W-1:0] fd_pc,
    output logic              fd_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q,         pc_d;
    logic              req_valid_q,  req_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [31:0]       skid_insn_q,  skid_insn_d;
    logic [ADDR_W-1:0] skid_pc_q,    skid_pc_d;
    logic [31:0]       fd_insn_q,    fd_insn_d;
    logic [ADDR_W-1:0] fd_pc_q,      fd_pc_d;
    logic              fd_valid_q,   fd_valid_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q         <= '0;
            req_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_insn_q  <= NOP_INSN;
            skid_pc_q    <= '0;
            fd_insn_q    <= NOP_INSN;
            fd_pc_q      <= '0;
            fd_valid_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            skid_valid_q <= skid_valid_d;
            skid_insn_q  <= skid_insn_d;
            skid_pc_q    <= skid_pc_d;
            fd_insn_q    <= fd_insn_d;
            fd_pc_q      <= fd_pc_d;
            fd_valid_q   <= fd_valid_d;
        end
    end

    // While req_valid_q is set, pc_q already equals the issued address + 1.
    always_comb begin
        pc_d         = pc_q;
        req_valid_d  = 1'b0;
        skid_valid_d = skid_valid_q;
        skid_insn_d  = skid_insn_q;
        skid_pc_d    = skid_pc_q;
        fd_insn_d    = fd_insn_q;
        fd_pc_d      = fd_pc_q;
        fd_valid_d   = fd_valid_q;
        if (redirect) begin
            pc_d         = redirect_target;
            skid_valid_d = 1'b0;
            fd_insn_d    = NOP_INSN;
            fd_pc_d      = '0;
            fd_valid_d   = 1'b0;
        end else if (stall) begin
            if (req_valid_q && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_insn_d  = imem_q;
                skid_pc_d    = pc_q;
            end
        end else begin
            pc_d        = pc_q + PC_ONE;
            req_valid_d = 1'b1;
            if (skid_valid_q) begin
                fd_insn_d    = skid_insn_q;
                fd_pc_d      = skid_pc_q;
                fd_valid_d   = 1'b1;
                skid_valid_d = 1'b0;
            end else if (req_valid_q) begin
                fd_insn_d  = imem_q;
                fd_pc_d    = pc_q;
                fd_valid_d = 1'b1;
            end else begin
                fd_insn_d  = NOP_INSN;
                fd_valid_d = 1'b0;
            end
        end
    end

    assign imem_addr = pc_q;
    assign fd_insn   = fd_insn_q;
    assign fd_pc     = fd_pc_q;
    assign fd_valid  = fd_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (!stall && !redirect && fd_valid_d && (fetch_count_q != 32'hFFFF_FFFF))
            fetch_count_d = fetch_count_q + 32'd1;
        if (stall && !redirect && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_d = stall_count_q + 32'd1;
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: ROM word i = 32'h1000_0000 + i.
// Build with FETCH_PERF_EN defined to also exercise the event counters.
module tb_fetch_stage;

    localparam int ADDR_W = 12;

    logic              clock;
    logic              reset;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_q;
    logic [31:0]       fd_insn;
    logic [ADDR_W-1:0] fd_pc;
    logic              fd_valid;
`ifdef FETCH_PERF_EN
    logic [31:0]       fetch_count;
    logic [31:0]       stall_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage #(.ADDR_W(ADDR_W), .NOP_INSN(32'h0000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_q          (imem_q),
        .fd_insn         (fd_insn),
        .fd_pc           (fd_pc),
        .fd_valid        (fd_valid)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) imem_q <= 32'h1000_0000 + {20'h0, imem_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_fd(input string tag, input logic [31:0] insn, input logic [31:0] pc,
                          input logic valid);
        chk({tag, "_insn"},  fd_insn, insn);
        chk({tag, "_pc"},    32'(fd_pc), pc);
        chk({tag, "_valid"}, 32'(fd_valid), 32'(valid));
    endtask

    function automatic logic [31:0] w(input int a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        #1;
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk_fd("rst", 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // streaming: edge k issues address k-1, fd shows word k-2
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("run_addr%0d", k), 32'(imem_addr), 32'(k));
            if (k >= 2) chk_fd($sformatf("run%0d", k), w(k - 2), 32'(k - 1), 1'b1);
            else        chk("run1_valid", 32'(fd_valid), 32'h0);
        end

        // address 5 in flight; stall three edges
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stl_addr%0d", k), 32'(imem_addr), 32'd6);
            chk_fd($sformatf("stl%0d", k), w(4), 32'd5, 1'b1);
        end
        stall = 1'b0;
        tick(); chk_fd("rel0", w(5), 32'd6, 1'b1);
        tick(); chk_fd("rel1", w(6), 32'd7, 1'b1);
        tick(); chk_fd("rel2", w(7), 32'd8, 1'b1);
        tick(); chk_fd("rel3", w(8), 32'd9, 1'b1);
        chk("pre_redir_addr", 32'(imem_addr), 32'd10);

        // redirect with word 9 in flight and address 10 on the bus
        redirect = 1'b1; redirect_target = 12'h080;
        tick();
        redirect = 1'b0;
        chk_fd("redir0", 32'h0, 32'h0, 1'b0);
        chk("redir_addr", 32'(imem_addr), 32'h080);
        tick(); chk_fd("redir1", 32'h0, 32'h0, 1'b0);
        tick(); chk_fd("redir2", w(12'h080), 32'h081, 1'b1);
        tick(); chk_fd("redir3", w(12'h081), 32'h082, 1'b1);

        // fill skid with word 0x82, then stall+redirect together
        stall = 1'b1;
        tick(); chk_fd("sr_stall", w(12'h081), 32'h082, 1'b1);
        redirect = 1'b1; redirect_target = 12'h200;
        tick();
        stall = 1'b0; redirect = 1'b0;
        chk_fd("sr0", 32'h0, 32'h0, 1'b0);
        chk("sr_addr", 32'(imem_addr), 32'h200);
        tick(); chk_fd("sr1", 32'h0, 32'h0, 1'b0);
        tick(); chk_fd("sr2", w(12'h200), 32'h201, 1'b1);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_target = 12'hFFE;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        chk("wrap_addr", 32'(imem_addr), 32'h0);
        chk_fd("wrap0", w(12'hFFE), 32'hFFF, 1'b1);
        tick(); chk_fd("wrap1", w(12'hFFF), 32'h0, 1'b1);

        // asynchronous reset between edges while stalled
        stall = 1'b1;
        tick();
        #1 reset = 1'b0;
        #1;
        chk("arst_addr", 32'(imem_addr), 32'h0);
        chk_fd("arst", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
        chk("arst_fcnt", fetch_count, 32'h0);
        chk("arst_scnt", stall_count, 32'h0);
`endif
        @(negedge clock);
        stall = 1'b0;
        reset = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("rs_addr%0d", k), 32'(imem_addr), 32'(k));
            if (k == 2) chk_fd("rs2", w(0), 32'd1, 1'b1);
        end
        chk_fd("rs11", w(9), 32'd10, 1'b1);
        stall = 1'b1;
        tick(); tick(); tick();
        chk_fd("rs_stl", w(9), 32'd10, 1'b1);
        chk("rs_stl_addr", 32'(imem_addr), 32'd11);
`ifdef FETCH_PERF_EN
        chk("perf_fcnt", fetch_count, 32'd10);
        chk("perf_scnt", stall_count, 32'd3);
        #1 reset = 1'b0;
        #1;
        chk("perf_fcnt_rst", fetch_count, 32'h0);
        chk("perf_scnt_rst", stall_count, 32'h0);
`endif
        stall = 1'b0;
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
